// File: rtl/regfile_dump_if.sv
// regfile_dump_if: bundles the register-file read port and the byte output
// stream of the register dump reader. The master side is the dump reader.
interface regfile_dump_if #(
    parameter int ADDR_W = 2,
    parameter int DATA_W = 8
);
    logic [ADDR_W-1:0] rd_addr;
    logic [DATA_W-1:0] rd_data;
    logic              out_valid;
    logic              out_ready;
    logic [DATA_W-1:0] out_data;
    logic [ADDR_W-1:0] out_index;
    logic              out_last;

    modport master (
        output rd_addr,
        input  rd_data,
        output out_valid,
        input  out_ready,
        output out_data,
        output out_index,
        output out_last
    );

    modport slave (
        input  rd_addr,
        output rd_data,
        input  out_valid,
        output out_ready,
        input  out_data,
        input  out_index,
        input  out_last
    );
endinterface

// File: rtl/regfile_dump.sv
// regfile_dump: on a start pulse, reads registers 0..NUM_REGS-1 one at a time
// through a combinational read port and emits each value as a byte on a
// valid/ready stream. Define REGDUMP_CHECKSUM_EN to append a modulo-256 sum
// byte after the last register byte.
//
// state | meaning
// IDLE  | waiting for start; rd_addr parked at 0
// FETCH | rd_addr = addr; read data captured into the output byte
// SEND  | byte presented, held until out_ready
// CSUM  | checksum byte: first cycle loads it, then held until out_ready
module regfile_dump #(
    parameter int NUM_REGS = 4,
    parameter int ADDR_W   = 2,
    parameter int DATA_W   = 8
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            start,
    regfile_dump_if.master  bus,
    output logic            busy,
    output logic            done
);
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        SEND  = 2'd2,
        CSUM  = 2'd3
    } state_t;

    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(NUM_REGS - 1);

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic              out_valid_q, out_valid_d;
    logic [DATA_W-1:0] out_data_q, out_data_d;
    logic [ADDR_W-1:0] out_index_q, out_index_d;
    logic              out_last_q, out_last_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;
`ifdef REGDUMP_CHECKSUM_EN
    logic [DATA_W-1:0] sum_q, sum_d;
`endif

    // Next-state and next-output computation for the dump sequencer.
    always_comb begin
        state_d     = state_q;
        addr_d      = addr_q;
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        out_index_d = out_index_q;
        out_last_d  = out_last_q;
        done_d      = 1'b0;
`ifdef REGDUMP_CHECKSUM_EN
        sum_d       = sum_q;
`endif
        case (state_q)
            IDLE: begin
                if (start) begin
                    addr_d  = '0;
                    state_d = FETCH;
`ifdef REGDUMP_CHECKSUM_EN
                    sum_d   = '0;
`endif
                end
            end
            FETCH: begin
                out_data_d  = bus.rd_data;
                out_index_d = addr_q;
                out_valid_d = 1'b1;
`ifdef REGDUMP_CHECKSUM_EN
                out_last_d  = 1'b0;
                sum_d       = sum_q + bus.rd_data;
`else
                out_last_d  = (addr_q == LAST_ADDR);
`endif
                state_d     = SEND;
            end
            SEND: begin
                if (bus.out_ready) begin
                    out_valid_d = 1'b0;
                    out_last_d  = 1'b0;
                    if (addr_q != LAST_ADDR) begin
                        addr_d  = addr_q + ADDR_W'(1);
                        state_d = FETCH;
                    end else begin
                        addr_d  = '0;
`ifdef REGDUMP_CHECKSUM_EN
                        state_d = CSUM;
`else
                        state_d = IDLE;
                        done_d  = 1'b1;
`endif
                    end
                end
            end
`ifdef REGDUMP_CHECKSUM_EN
            CSUM: begin
                // out_valid is low on entry, so the first cycle just loads the sum
                if (!out_valid_q) begin
                    out_data_d  = sum_q;
                    out_index_d = '0;
                    out_last_d  = 1'b1;
                    out_valid_d = 1'b1;
                end else if (bus.out_ready) begin
                    out_valid_d = 1'b0;
                    out_last_d  = 1'b0;
                    state_d     = IDLE;
                    done_d      = 1'b1;
                end
            end
`endif
            default: begin
                state_d     = IDLE;
                addr_d      = '0;
                out_valid_d = 1'b0;
                out_last_d  = 1'b0;
            end
        endcase
        busy_d = (state_d != IDLE);
    end

    // Sequencer state and registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            addr_q      <= '0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_index_q <= '0;
            out_last_q  <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
`ifdef REGDUMP_CHECKSUM_EN
            sum_q       <= '0;
`endif
        end else begin
            state_q     <= state_d;
            addr_q      <= addr_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            out_index_q <= out_index_d;
            out_last_q  <= out_last_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
`ifdef REGDUMP_CHECKSUM_EN
            sum_q       <= sum_d;
`endif
        end
    end

    assign bus.rd_addr   = addr_q;
    assign bus.out_valid = out_valid_q;
    assign bus.out_data  = out_data_q;
    assign bus.out_index = out_index_q;
    assign bus.out_last  = out_last_q;
    assign busy          = busy_q;
    assign done          = done_q;
endmodule

// File: tb/tb_regfile_dump.sv
// Bench for regfile_dump: table of dump scenarios plus randomized runs, each
// checked against a reference built from the register contents and the
// chosen out_ready pattern; a hand-written mid-dump reset sequence.
module tb_regfile_dump;
    localparam int NUM_REGS = 4;
    localparam int ADDR_W   = 2;
    localparam int DATA_W   = 8;
`ifdef REGDUMP_CHECKSUM_EN
    localparam int NBYTES   = NUM_REGS + 1;
`else
    localparam int NBYTES   = NUM_REGS;
`endif
    localparam int DONE_FULL = 2 * NBYTES + 1;
    localparam int LIMIT     = 200;

    logic clk   = 1'b0;
    logic rst_n = 1'b1;
    logic start = 1'b0;
    logic busy, done;
    logic [7:0] regs [NUM_REGS];

    regfile_dump_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();
    assign bus.rd_data = regs[bus.rd_addr];

    regfile_dump #(.NUM_REGS(NUM_REGS), .ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .start (start),
        .bus   (bus),
        .busy  (busy),
        .done  (done)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    typedef struct {
        logic [3:0][7:0] r;
        int              rmode;    // 0: ready always, 1: toggle, 2: random
        bit              restart;  // start again during SEND of index 1
        bit              wr;       // reg3<=0x99, reg0<=0x5A during FETCH of index 1
        int              exp_done; // >0: fixed expected done cycle
    } vec_t;

    bit rdy [LIMIT+2];

    task automatic run_dump(input logic [3:0][7:0] r, input int rmode, input bit restart,
                            input bit wr, input int exp_done, input string tag);
        logic [7:0] e [NBYTES];
        int sum, t, s, done_ref, c, n_done, done_c, busy_bad, stab_bad;
        logic [7:0] got_d [$];
        int got_i [$];
        logic got_l [$];
        logic pv, pa, acc, pl;
        logic [7:0] pd;
        logic [ADDR_W-1:0] pi;

        for (int i = 0; i < NUM_REGS; i++) regs[i] = r[i];
        for (int k = 0; k <= LIMIT + 1; k++) begin
            if (rmode == 0)      rdy[k] = 1'b1;
            else if (rmode == 1) rdy[k] = (k % 2 == 1);
            else                 rdy[k] = ($urandom_range(0, 99) < 60);
        end

        // Snapshot rule: a write landing before a register's fetch is seen.
        sum = 0;
        for (int i = 0; i < NUM_REGS; i++) e[i] = r[i];
        if (wr) e[3] = 8'h99;
        for (int i = 0; i < NUM_REGS; i++) sum = (sum + int'(e[i])) % 256;
`ifdef REGDUMP_CHECKSUM_EN
        e[NUM_REGS] = sum[7:0];
`endif
        // Each byte takes one load cycle then waits in SEND until ready.
        t = 1;
        for (int k = 0; k < NBYTES; k++) begin
            s = t + 1;
            while (s < LIMIT && !rdy[s]) s++;
            t = s + 1;
        end
        done_ref = (exp_done > 0) ? exp_done : t;

        start = 1'b1;
        bus.out_ready = rdy[0];
        @(posedge clk); #1;
        start = 1'b0;
        c = 1; n_done = 0; done_c = -1; busy_bad = 0; stab_bad = 0;
        pv = 1'b0; pa = 1'b0; pd = '0; pi = '0; pl = 1'b0;
        while (c <= LIMIT) begin
            bus.out_ready = rdy[c];
            if (wr && c == 3) begin
                regs[3] = 8'h99;
                regs[0] = 8'h5A;
            end
            start = (restart && c == 4);
            if (busy !== (c < done_ref)) busy_bad++;
            if (bus.out_valid && pv && !pa &&
                (bus.out_data !== pd || bus.out_index !== pi || bus.out_last !== pl))
                stab_bad++;
            acc = bus.out_valid && rdy[c];
            if (acc) begin
                got_d.push_back(bus.out_data);
                got_i.push_back(int'(bus.out_index));
                got_l.push_back(bus.out_last);
            end
            if (done) begin
                n_done++;
                if (n_done == 1) done_c = c;
            end
            pv = bus.out_valid; pa = acc; pd = bus.out_data; pi = bus.out_index; pl = bus.out_last;
            if (n_done > 0 && c >= done_c + 3) break;
            @(posedge clk); #1;
            c++;
        end
        start = 1'b0;
        bus.out_ready = 1'b0;

        check({tag, ".done_seen"}, 32'(n_done > 0), 32'd1);
        check({tag, ".done_count"}, 32'(n_done), 32'd1);
        check({tag, ".done_cycle"}, 32'(done_c), 32'(done_ref));
        check({tag, ".nbytes"}, 32'(got_d.size()), 32'(NBYTES));
        for (int k = 0; k < NBYTES && k < got_d.size(); k++) begin
            check($sformatf("%s.data%0d", tag, k), 32'(got_d[k]), 32'(e[k]));
            check($sformatf("%s.index%0d", tag, k), 32'(got_i[k]), 32'((k < NUM_REGS) ? k : 0));
            check($sformatf("%s.last%0d", tag, k), 32'(got_l[k]), 32'(k == NBYTES - 1));
        end
        check({tag, ".busy"}, 32'(busy_bad), 32'd0);
        check({tag, ".stable"}, 32'(stab_bad), 32'd0);
        check({tag, ".idle_addr"}, 32'(bus.rd_addr), 32'd0);
        check({tag, ".idle_valid"}, 32'(bus.out_valid), 32'd0);
    endtask

    task automatic reset_mid_dump();
        int extra_done;
        for (int i = 0; i < NUM_REGS; i++) regs[i] = 8'(8'h11 * (i + 1));
        bus.out_ready = 1'b1;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (5) begin
            @(posedge clk); #1;
        end
        check("rst.pre_valid", 32'(bus.out_valid), 32'd1);
        check("rst.pre_index", 32'(bus.out_index), 32'd2);
        rst_n = 1'b0;
        #1;
        check("rst.valid", 32'(bus.out_valid), 32'd0);
        check("rst.data", 32'(bus.out_data), 32'd0);
        check("rst.index", 32'(bus.out_index), 32'd0);
        check("rst.last", 32'(bus.out_last), 32'd0);
        check("rst.busy", 32'(busy), 32'd0);
        check("rst.done", 32'(done), 32'd0);
        check("rst.rd_addr", 32'(bus.rd_addr), 32'd0);
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        extra_done = 0;
        repeat (4) begin
            @(posedge clk); #1;
            if (done || busy) extra_done++;
        end
        check("rst.no_done", 32'(extra_done), 32'd0);
        bus.out_ready = 1'b0;
    endtask

    vec_t tbl [6];

    initial begin
        tbl[0] = '{32'h44332211, 0, 1'b0, 1'b0, DONE_FULL};
        tbl[1] = '{32'h44332211, 1, 1'b0, 1'b0, 0};
        tbl[2] = '{32'h44332211, 0, 1'b1, 1'b0, DONE_FULL};
        tbl[3] = '{32'h44332211, 0, 1'b0, 1'b1, DONE_FULL};
        tbl[4] = '{32'h201001FF, 0, 1'b0, 1'b0, DONE_FULL};
        tbl[5] = '{32'hFF7F8000, 2, 1'b0, 1'b0, 0};

        for (int i = 0; i < NUM_REGS; i++) regs[i] = '0;
        bus.out_ready = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        check("reset.valid", 32'(bus.out_valid), 32'd0);
        check("reset.data", 32'(bus.out_data), 32'd0);
        check("reset.index", 32'(bus.out_index), 32'd0);
        check("reset.last", 32'(bus.out_last), 32'd0);
        check("reset.busy", 32'(busy), 32'd0);
        check("reset.done", 32'(done), 32'd0);
        check("reset.rd_addr", 32'(bus.rd_addr), 32'd0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;

        for (int i = 0; i < 6; i++)
            run_dump(tbl[i].r, tbl[i].rmode, tbl[i].restart, tbl[i].wr, tbl[i].exp_done,
                     $sformatf("vec%0d", i));

        reset_mid_dump();
        run_dump(tbl[0].r, 0, 1'b0, 1'b0, DONE_FULL, "after_reset");

        for (int i = 0; i < 6; i++) begin
            logic [3:0][7:0] rr;
            rr = {8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)),
                  8'($urandom_range(0, 255)), 8'($urandom_range(0, 255))};
            run_dump(rr, 2, 1'b0, 1'b0, 0, $sformatf("rand%0d", i));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/regfile_dump.md
# regfile_dump

Sequential reader for the 4 x 8-bit register file: on a start pulse it walks register addresses 0..NUM_REGS-1 through one register-file read port, captures each value, and emits it as a byte on a valid/ready output stream. It sits between the register file's read port and a debug/display consumer (LED/7-segment driver or serial transmitter), giving the design a non-intrusive register dump path.

## Interface
- NUM_REGS, 4, number of registers scanned (power of two, 2..16)
- ADDR_W, 2, register address width, equals log2(NUM_REGS)
- DATA_W, 8, register data width
- clk  input  1  system clock, all state on rising edge
- rst_n  input  1  reset, asynchronous, active-low
- start  input  1  request a dump; sampled only in IDLE
- rd_addr  output  ADDR_W  address driven to the register file read port
- rd_data  input  DATA_W  combinational read data returned for rd_addr
- out_valid  output  1  out_data/out_index/out_last valid
- out_ready  input  1  consumer accepts the current byte
- out_data  output  DATA_W  captured register value (or checksum)
- out_index  output  ADDR_W  register index of out_data
- out_last  output  1  current byte is the final byte of the dump
- busy  output  1  high in any state other than IDLE
- done  output  1  one-cycle pulse after the final byte is accepted

## Operation
- States: IDLE, FETCH, SEND, CSUM (macro only).
- IDLE: busy=0, out_valid=0; start=1 -> addr counter=0, go FETCH.
- FETCH: rd_addr=addr; rd_data captured into out_data, out_index=addr; go SEND.
- SEND: out_valid=1, outputs held stable until out_valid&&out_ready.
  - handshake, addr<NUM_REGS-1 -> addr+1, go FETCH.
  - handshake, addr==NUM_REGS-1 -> go CSUM (macro) or IDLE with done=1 next cycle.
- out_last=1 in SEND for the final byte only (addr==NUM_REGS-1 without macro; never with macro).
- rd_addr is driven from the addr counter in every state; equals 0 in IDLE.
- Snapshot semantics: each register sampled at its own FETCH cycle; writes to a register before its FETCH are reflected, after are not. No atomic snapshot.
- start while busy: ignored, no queuing.
- out_ready high while out_valid low: no effect.

## Timing
- Reset (rst_n=0, asynchronous): state=IDLE, addr=0, rd_addr=0, out_valid=0, out_data=0, out_index=0, out_last=0, busy=0, done=0, checksum accumulator=0.
- Reset mid-dump: dump aborted immediately, no done pulse; next start restarts from register 0.
- start sampled at edge N -> FETCH in cycle N+1, out_valid=1 from cycle N+2.
- Per byte: minimum 2 cycles (FETCH + SEND) with out_ready held high; full dump of 4 regs = 8 cycles, done asserted in cycle N+9.
- busy rises the cycle after start is sampled and falls in the same cycle done pulses.
- out_ready stall: SEND held indefinitely, outputs unchanged, no further reads issued.

## Configuration
- Macro REGDUMP_CHECKSUM_EN.
- Defined: an 8-bit accumulator sums each captured byte modulo 256 (cleared on start). After the last register byte is accepted, CSUM state presents out_data=sum, out_index=0, out_last=1, out_valid=1; on handshake -> IDLE, done pulse. Dump length NUM_REGS+1 bytes; 4-register dump = 10 cycles to done.
- Undefined: no accumulator, no CSUM state; dump length NUM_REGS bytes, out_last on register NUM_REGS-1.

## Test plan
- Regs = 0x11,0x22,0x33,0x44, start pulse, out_ready=1 -> bytes 0x11..0x44 with out_index 0..3, out_last only on 0x44, done pulse 9 cycles after start.
- Same contents, out_ready toggled 1/0 each cycle -> identical byte sequence, each byte held stable while out_ready=0, no duplicates or drops.
- start asserted again during SEND of index 1 -> ignored; exactly 4 bytes and one done pulse.
- rst_n pulled low during SEND of index 2 -> all outputs 0 immediately, no done; subsequent start dumps from index 0.
- Write reg3=0x99 during FETCH of index 1 -> byte for index 3 is 0x99.
- With REGDUMP_CHECKSUM_EN, regs 0xFF,0x01,0x10,0x20 -> fifth byte 0x30 with out_last=1, out_index=0; done 11 cycles after start.
